// File: rtl/nvram_restore_pkg.sv
// Shared definitions for the NVRAM restore block: FSM state encoding and
// default ioctl index / pause padding shared with the extract side.
package nvram_restore_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DELAY   = 3'd1,
        S_PAUSE   = 3'd2,
        S_READ    = 3'd3,
        S_WRITE   = 3'd4,
        S_VERIFY  = 3'd5,
        S_RELEASE = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    localparam int DUMPINDEX_DEF = 4;
    localparam int PAUSEPAD_DEF  = 4;

endpackage

// File: rtl/nvram_restore_spram_hs.sv
// Single-port byte RAM with registered read, used as the dump buffer.
module spram_hs #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_d,
    output logic [DW-1:0] o_q
);

    logic [DW-1:0] r_mem [0:(2**AW)-1];
    logic [DW-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_addr] <= i_d;
        r_q <= r_mem[i_addr];
    end

    assign o_q = r_q;

endmodule

// File: rtl/nvram_restore.sv
// Captures an ioctl NVRAM dump and, after a start delay, pauses the CPU and writes
// it back into game NVRAM. Define NVRAM_RESTORE_VERIFY_EN for per-byte readback.
module nvram_restore
    import nvram_restore_pkg::*;
#(
    parameter int          DUMPWIDTH  = 8,
    parameter int          DUMPINDEX  = DUMPINDEX_DEF,
    parameter int          PAUSEPAD   = PAUSEPAD_DEF,
    parameter logic [31:0] STARTDELAY = 32'd1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 paused,
    input  logic                 ioctl_download,
    input  logic                 ioctl_wr,
    input  logic [24:0]          ioctl_addr,
    input  logic [7:0]           ioctl_index,
    input  logic [7:0]           ioctl_dout,
    output logic [DUMPWIDTH-1:0] nvram_address,
    output logic [7:0]           nvram_data_in,
    output logic                 nvram_we,
    input  logic [7:0]           nvram_data_out,
    output logic                 pause_cpu,
    output logic                 restore_done,
    output logic                 verify_error
);

    localparam logic [25:0] DEPTH = 26'(1) << DUMPWIDTH;

    state_t               r_state;
    logic [31:0]          r_timer;
    logic [DUMPWIDTH-1:0] r_addr;
    logic [DUMPWIDTH:0]   r_len;
    logic                 r_dl_q;
    logic                 r_first;
    logic                 r_pause;
    logic                 r_we;
    logic                 r_done;

    logic                 w_dl;
    logic                 w_cap;
    logic                 w_rise;
    logic                 w_fall;
    logic                 w_in_range;
    logic                 w_buf_we;
    logic [DUMPWIDTH:0]   w_wr_len;
    logic [DUMPWIDTH:0]   w_len_base;
    logic [DUMPWIDTH:0]   w_addr_inc;
    logic [DUMPWIDTH-1:0] w_ram_addr;
    logic [7:0]           w_q;

    assign w_dl       = ioctl_download && (ioctl_index == 8'(DUMPINDEX));
    assign w_cap      = (r_state == S_IDLE) || (r_state == S_DELAY);
    assign w_rise     = w_dl && !r_dl_q;
    assign w_fall     = !w_dl && r_dl_q;
    assign w_in_range = ({1'b0, ioctl_addr} < DEPTH);
    assign w_buf_we   = w_cap && w_dl && ioctl_wr && w_in_range;
    assign w_wr_len   = {1'b0, ioctl_addr[DUMPWIDTH-1:0]} + {{DUMPWIDTH{1'b0}}, 1'b1};
    assign w_len_base = w_rise ? '0 : r_len;
    assign w_addr_inc = {1'b0, r_addr} + {{DUMPWIDTH{1'b0}}, 1'b1};
    assign w_ram_addr = w_cap ? ioctl_addr[DUMPWIDTH-1:0] : r_addr;

    spram_hs #(.AW(DUMPWIDTH), .DW(8)) u_buf (
        .i_clk  (clk),
        .i_we   (w_buf_we),
        .i_addr (w_ram_addr),
        .i_d    (ioctl_dout),
        .o_q    (w_q)
    );

    // Dump length survives core reset so a held dump is re-applied every boot.
    always_ff @(posedge clk) begin
        r_dl_q <= w_dl;
        if (w_cap) begin
            if (w_buf_we && (w_wr_len > w_len_base)) r_len <= w_wr_len;
            else if (w_rise)                         r_len <= '0;
        end
    end

`ifdef NVRAM_RESTORE_VERIFY_EN
    logic r_verr;
    assign verify_error = r_verr;
`else
    logic w_unused;
    assign w_unused     = ^nvram_data_out;
    assign verify_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_addr  <= '0;
            r_pause <= 1'b0;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
            r_first <= 1'b1;
`ifdef NVRAM_RESTORE_VERIFY_EN
            r_verr  <= 1'b0;
`endif
        end else begin
            r_first <= 1'b0;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_dl && (w_fall || r_first) && (r_len != '0)) begin
                        r_timer <= STARTDELAY;
                        r_state <= S_DELAY;
`ifdef NVRAM_RESTORE_VERIFY_EN
                        r_verr  <= 1'b0;
`endif
                    end
                end
                S_DELAY: begin
                    if (w_dl) begin
                        r_state <= S_IDLE;
                    end else if (r_timer <= 32'd1) begin
                        r_pause <= 1'b1;
                        r_timer <= 32'(PAUSEPAD);
                        r_state <= S_PAUSE;
                    end else begin
                        r_timer <= r_timer - 32'd1;
                    end
                end
                S_PAUSE: begin
                    if (paused) begin
                        if (r_timer <= 32'd1) begin
                            r_addr  <= '0;
                            r_state <= S_READ;
                        end else begin
                            r_timer <= r_timer - 32'd1;
                        end
                    end
                end
                S_READ: begin
                    r_we    <= 1'b1;
                    r_state <= S_WRITE;
                end
                // With readback enabled the advance decision moves from WRITE to VERIFY.
                S_WRITE: begin
`ifdef NVRAM_RESTORE_VERIFY_EN
                    r_state <= S_VERIFY;
                end
                S_VERIFY: begin
                    if (nvram_data_out != w_q) r_verr <= 1'b1;
`endif
                    if (w_addr_inc == r_len) begin
                        r_timer <= 32'(PAUSEPAD);
                        r_state <= S_RELEASE;
                    end else begin
                        r_addr  <= w_addr_inc[DUMPWIDTH-1:0];
                        r_state <= S_READ;
                    end
                end
                S_RELEASE: begin
                    if (r_timer <= 32'd1) begin
                        r_pause <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_timer <= r_timer - 32'd1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign nvram_address = r_addr;
    assign nvram_data_in = w_q;
    assign nvram_we      = r_we;
    assign pause_cpu     = r_pause;
    assign restore_done  = r_done;

endmodule

// File: tb/tb_nvram_restore.sv
// Scoreboard bench for nvram_restore: expected NVRAM writes are queued by the
// stimulus thread and popped by a negedge monitor; timing checked in cycles.
module tb_nvram_restore;

    localparam int DW = 4;
`ifdef NVRAM_RESTORE_VERIFY_EN
    localparam int GAP  = 3;  // WRITE, VERIFY, READ per byte
    localparam int TAIL = 6;  // last write -> VERIFY -> 4 pad edges + transition
`else
    localparam int GAP  = 2;
    localparam int TAIL = 5;  // last write -> RELEASE -> 4 pad edges
`endif
    localparam int DELAY_EDGES = 17;  // edge sampling dl fall + STARTDELAY(16)

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          paused;
    logic          ioctl_download = 1'b0;
    logic          ioctl_wr = 1'b0;
    logic [24:0]   ioctl_addr = '0;
    logic [7:0]    ioctl_index = 8'd4;
    logic [7:0]    ioctl_dout = '0;
    logic [DW-1:0] nvram_address;
    logic [7:0]    nvram_data_in;
    logic          nvram_we;
    logic [7:0]    nvram_data_out;
    logic          pause_cpu;
    logic          restore_done;
    logic          verify_error;

    nvram_restore #(.DUMPWIDTH(DW), .DUMPINDEX(4), .PAUSEPAD(4), .STARTDELAY(32'd16)) dut (
        .clk(clk), .reset_n(reset_n), .paused(paused),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_index(ioctl_index), .ioctl_dout(ioctl_dout),
        .nvram_address(nvram_address), .nvram_data_in(nvram_data_in), .nvram_we(nvram_we),
        .nvram_data_out(nvram_data_out), .pause_cpu(pause_cpu),
        .restore_done(restore_done), .verify_error(verify_error)
    );

    always #5 clk = ~clk;

    // Game NVRAM and CPU pause models
    logic [7:0] gmem [0:15];
    logic       p1 = 1'b0, p2 = 1'b0, hold = 1'b0, corrupt = 1'b0;
    int         cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        p1  <= pause_cpu;
        p2  <= p1;
        if (nvram_we) gmem[nvram_address] <= nvram_data_in;
    end
    assign paused         = hold ? 1'b0 : p2;
    assign nvram_data_out = (corrupt && nvram_address == 4'd2) ? 8'hFF : gmem[nvram_address];

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", nm, got, exp);
        end
    endtask

    logic [11:0] exp_q[$];
    int   n_wr = 0, last_wr_cyc = 0, last_addr = 0, done_cyc = 0, fall_cyc = 0, done_cnt = 0;
    bit   prev_wr_valid = 0, pause_seen = 0, prev_pause = 0, prev_done = 0;

    // Monitor: pops the scoreboard on every write strobe
    always @(negedge clk) begin
        logic [11:0] e;
        if (nvram_we) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write addr=%0d data=0x%02h", nvram_address, nvram_data_in);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr_data", {nvram_address, nvram_data_in}, e);
            end
            if (prev_wr_valid) chk("write_gap", cyc - last_wr_cyc, GAP);
            prev_wr_valid = 1;
            last_wr_cyc   = cyc;
            last_addr     = nvram_address;
            n_wr++;
        end
        if (pause_cpu) pause_seen = 1;
        if (prev_pause && !pause_cpu) fall_cyc = cyc;
        if (prev_done) chk("done_width", restore_done, 0);
        if (restore_done) begin
            done_cnt++;
            done_cyc      = cyc;
            prev_wr_valid = 0;
        end
        if (!reset_n) prev_wr_valid = 0;
        prev_pause = pause_cpu;
        prev_done  = restore_done;
    end

    function automatic bit sig(input int w);
        case (w)
            0:       return pause_cpu;
            1:       return nvram_we;
            2:       return restore_done;
            default: return !pause_cpu;
        endcase
    endfunction

    // Counts negedges until the selected condition holds, bounded
    task automatic wait_for(input int w, input string nm, output int dt);
        dt = 0;
        do begin
            @(negedge clk);
            dt++;
        end while (!sig(w) && dt < 2000);
        chk({nm, "_seen"}, sig(w), 1);
    endtask

    logic [7:0] pat [16];

    task automatic dl_run(input int n, input bit push, input bit oob);
        @(negedge clk);
        ioctl_download = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = pat[i];
            @(negedge clk);
            ioctl_wr = 1'b0;
            if (push) exp_q.push_back({4'(i), pat[i]});
        end
        if (oob) begin  // aliases addr 4 if not range-checked
            @(negedge clk);
            ioctl_wr = 1'b1; ioctl_addr = 25'd20; ioctl_dout = 8'hEE;
            @(negedge clk);
            ioctl_wr = 1'b0;
        end
        @(negedge clk);
        ioctl_download = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int dt, n0, d0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_pause", pause_cpu, 0);
        chk("rst_we", nvram_we, 0);
        chk("rst_done", restore_done, 0);
        chk("rst_verr", verify_error, 0);
        chk("rst_addr", nvram_address, 0);
        reset_n = 1'b1;

        // Zero-length download: no restore at all
        pause_seen = 0; n0 = n_wr;
        dl_run(0, 0, 0);
        repeat (60) @(negedge clk);
        chk("zero_len_pause", pause_seen, 0);
        chk("zero_len_writes", n_wr - n0, 0);

        // Basic 4-byte restore with an ignored out-of-range byte
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
        n0 = n_wr; d0 = done_cnt;
        dl_run(4, 1, 1);
        wait_for(0, "pause_rise", dt);
        chk("start_delay", dt, DELAY_EDGES);
        wait_for(1, "first_write", dt);
        chk("pause_to_write", dt, 7);  // 2 pause-ack + 4 pad + READ
        wait_for(2, "done", dt);
        @(negedge clk);
        chk("tail_fall", fall_cyc - last_wr_cyc, TAIL);
        chk("tail_done", done_cyc - last_wr_cyc, TAIL);
        chk("basic_count", n_wr - n0, 4);
        chk("basic_done_cnt", done_cnt - d0, 1);
        chk("basic_q_empty", exp_q.size(), 0);

        // Full 16-byte dump: no wrap, no write after addr 15
        for (int i = 0; i < 16; i++) pat[i] = 8'(i);
        n0 = n_wr;
        dl_run(16, 1, 0);
        wait_for(2, "full_done", dt);
        repeat (10) @(negedge clk);
        chk("full_count", n_wr - n0, 16);
        chk("full_last_addr", last_addr, 15);
        chk("full_q_empty", exp_q.size(), 0);

        // Reset during the third write, then automatic rerun
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
        n0 = n_wr;
        dl_run(4, 0, 0);
        for (int i = 0; i < 3; i++) exp_q.push_back({4'(i), pat[i]});
        for (int i = 0; i < 4; i++) exp_q.push_back({4'(i), pat[i]});
        wait_for(1, "w0", dt);
        wait_for(1, "w1", dt);
        wait_for(1, "w2", dt);
        chk("third_write_addr", nvram_address, 2);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_pause", pause_cpu, 0);
        chk("rst_mid_we", nvram_we, 0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_for(0, "rerun_pause", dt);
        chk("rerun_delay", dt, DELAY_EDGES);
        wait_for(2, "rerun_done", dt);
        @(negedge clk);
        chk("rerun_count", n_wr - n0, 7);
        chk("rerun_q_empty", exp_q.size(), 0);

        // paused withheld: pad only counts confirmed cycles
        pat[0] = 8'h5A; pat[1] = 8'hA5; pat[2] = 8'h3C; pat[3] = 8'hC3;
        hold = 1'b1; n0 = n_wr;
        dl_run(4, 1, 0);
        wait_for(0, "hold_pause", dt);
        chk("hold_delay", dt, DELAY_EDGES);
        repeat (20) @(negedge clk);
        chk("hold_no_write", n_wr - n0, 0);
        hold = 1'b0;
        wait_for(1, "hold_first_write", dt);
        chk("hold_release_to_write", dt, 5);
        wait_for(2, "hold_done", dt);
        @(negedge clk);
        chk("hold_q_empty", exp_q.size(), 0);

        // Readback corruption at addr 2
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
        corrupt = 1'b1;
        dl_run(4, 1, 0);
`ifdef NVRAM_RESTORE_VERIFY_EN
        wait_for(1, "verr_w0", dt);
        wait_for(1, "verr_w1", dt);
        chk("verr_before_bad", verify_error, 0);
        wait_for(2, "verr_done", dt);
        repeat (5) @(negedge clk);
        chk("verr_sticky", verify_error, 1);
`else
        wait_for(2, "verr_done", dt);
        repeat (5) @(negedge clk);
        chk("verr_tied_low", verify_error, 0);
`endif
        chk("verr_q_empty", exp_q.size(), 0);
        corrupt = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
